// File: rtl/ic_ff_pkg.sv
// ---------------------------------------------------------------------------
// ic_ff_pkg
// Shared definitions for the emulated '74-family flip-flop bank.
//   ff_mode_e        : behaviour selector (D, JK, T) applied to every channel
//   EDGE_RISE/FALL   : pin-clock polarity selectors
//   SYNC_MIN/MAX     : legal synchroniser depths
//   CHANNELS_MAX     : widest bank the emulator fabric instantiates
//   ff_next()        : next-state of one flip-flop on an active pin edge
//   active_edge()    : per-bit active-edge detector for a chosen polarity
// ---------------------------------------------------------------------------
package ic_ff_pkg;

    typedef enum logic [1:0] {
        FF_MODE_D  = 2'd0,
        FF_MODE_JK = 2'd1,
        FF_MODE_T  = 2'd2
    } ff_mode_e;

    localparam bit EDGE_RISE = 1'b1;
    localparam bit EDGE_FALL = 1'b0;

    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;
    localparam int CHANNELS_MAX = 16;

    // Next state of a single flip-flop when its pin clock has an active edge.
    // In D mode dj is the data pin, in JK mode dj is J, in T mode dj is T.
    function automatic logic ff_next(
        input ff_mode_e mode,
        input logic     q,
        input logic     dj,
        input logic     k
    );
        logic nxt;
        nxt = q;
        case (mode)
            FF_MODE_D:  nxt = dj;
            FF_MODE_JK: begin
                case ({dj, k})
                    2'b00:   nxt = q;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = ~q;
                endcase
            end
            FF_MODE_T:  nxt = dj ? ~q : q;
            default:    nxt = q;
        endcase
        return nxt;
    endfunction

    // Active edge: current sample at the active level, previous sample not.
    function automatic logic active_edge(
        input bit   edge_sel,
        input logic cur,
        input logic prev
    );
        return (cur == edge_sel) && (prev != edge_sel);
    endfunction

endpackage

// File: rtl/ic_pin_sync.sv
// ---------------------------------------------------------------------------
// ic_pin_sync
// Generic multi-bit synchroniser: each bit of d passes through a STAGES-deep
// flop chain clocked by clk. Every input group of the flip-flop bank uses the
// same depth so that data pins stay aligned with the clock pin that samples
// them.
// Parameters:
//   WIDTH     : number of independent bits
//   STAGES    : chain depth (2..4)
//   RESET_VAL : value loaded into every stage on reset (inactive pin level)
// Ports:
//   clk   in  1      system clock
//   rst_n in  1      synchronous active-low reset
//   d     in  WIDTH  asynchronous pin inputs
//   q     out WIDTH  synchronised outputs (last stage)
// ---------------------------------------------------------------------------
module ic_pin_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Reset drives every stage to the inactive level so that in-flight pin
    // events are flushed and nothing reappears after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ic_ff_bank.sv
// ---------------------------------------------------------------------------
// ic_ff_bank
// Multi-channel emulator of '74-family edge-triggered flip-flops
// (74LS74/73/109/112 class). Each channel has its own pin clock and
// active-low preset/clear; every pin is synchronised into the CLK domain.
// Parameters:
//   CHANNELS    : number of independent flip-flops (1..16)
//   MODE        : 0 = D, 1 = JK, 2 = T (all channels)
//   EDGE        : 1 = rising pin-clock edge, 0 = falling pin-clock edge
//   SYNC_STAGES : synchroniser depth on every pin input (2..4)
// Ports:
//   CLK     in  1         system clock
//   RST_N   in  1         synchronous active-low reset
//   PIN_CLK in  CHANNELS  emulated pin clocks (asynchronous)
//   PRE_N   in  CHANNELS  preset, active low, level sensitive
//   CLR_N   in  CHANNELS  clear, active low, level sensitive
//   DJ      in  CHANNELS  D / J / T input depending on MODE
//   K       in  CHANNELS  K input (JK mode only)
//   Q       out CHANNELS  true output
//   QB      out CHANNELS  complement output (both high when PRE_N=CLR_N=0)
// Latency from a pin event sampled at CLK edge k to Q/QB is edge
// k+SYNC_STAGES, identically for clock, data, preset and clear pins.
// ---------------------------------------------------------------------------
module ic_ff_bank
    import ic_ff_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int MODE        = 0,
    parameter int EDGE        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] PIN_CLK,
    input  logic [CHANNELS-1:0] PRE_N,
    input  logic [CHANNELS-1:0] CLR_N,
    input  logic [CHANNELS-1:0] DJ,
    input  logic [CHANNELS-1:0] K,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] QB
);

    localparam ff_mode_e MODE_SEL = ff_mode_e'(2'(MODE));
    localparam bit       EDGE_SEL = (EDGE != 0) ? EDGE_RISE : EDGE_FALL;

    // Edge qualification stays off until the synchroniser has refilled with
    // real pin levels and the delayed copy has caught up with it.
    localparam int HOLDOFF = SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(HOLDOFF + 1);

    logic [CHANNELS-1:0] clk_sync;
    logic [CHANNELS-1:0] pre_sync;
    logic [CHANNELS-1:0] clr_sync;
    logic [CHANNELS-1:0] dj_sync;
    logic [CHANNELS-1:0] k_sync;

    logic [CHANNELS-1:0] clk_dly;
    logic [CNT_W-1:0]    holdoff_cnt;
    logic                qualified;
    logic [CHANNELS-1:0] edge_ok;

    logic [CHANNELS-1:0] q_r;
    logic [CHANNELS-1:0] qb_r;
    logic [CHANNELS-1:0] q_next;
    logic [CHANNELS-1:0] qb_next;

    // ---------------------------------------------------------------------
    // Input synchronisers, one per pin group, all the same depth.
    // Preset/clear reset to their inactive (high) level.
    // ---------------------------------------------------------------------
    ic_pin_sync #(
        .WIDTH     (CHANNELS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({CHANNELS{1'b0}})
    ) u_sync_clk (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (PIN_CLK),
        .q     (clk_sync)
    );

    ic_pin_sync #(
        .WIDTH     (CHANNELS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({CHANNELS{1'b1}})
    ) u_sync_pre (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (PRE_N),
        .q     (pre_sync)
    );

    ic_pin_sync #(
        .WIDTH     (CHANNELS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({CHANNELS{1'b1}})
    ) u_sync_clr (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (CLR_N),
        .q     (clr_sync)
    );

    ic_pin_sync #(
        .WIDTH     (CHANNELS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({CHANNELS{1'b0}})
    ) u_sync_dj (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (DJ),
        .q     (dj_sync)
    );

    ic_pin_sync #(
        .WIDTH     (CHANNELS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({CHANNELS{1'b0}})
    ) u_sync_k (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (K),
        .q     (k_sync)
    );

    // One-cycle-delayed copy of the synchronised pin clocks for edge detect.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clk_dly <= '0;
        end else begin
            clk_dly <= clk_sync;
        end
    end

    // Post-reset holdoff: counts up to HOLDOFF and then saturates. A pin
    // clock already at the active level at reset release produces one
    // apparent edge inside this window, which is thereby suppressed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            holdoff_cnt <= '0;
        end else if (!qualified) begin
            holdoff_cnt <= holdoff_cnt + 1'b1;
        end
    end

    assign qualified = (holdoff_cnt == CNT_W'(HOLDOFF));

    // ---------------------------------------------------------------------
    // Per-channel priority: both overrides > preset > clear > pin edge >
    // hold. Outside the overrides QB is recomputed as ~Q, which is also how
    // QB drops back to 0 when preset and clear release together.
    // Edges seen while an override is active are simply not used, so they
    // are discarded rather than deferred.
    // ---------------------------------------------------------------------
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic pre_act;
        logic clr_act;
        logic q_edge;

        assign edge_ok[ch] = qualified &&
                             active_edge(EDGE_SEL, clk_sync[ch], clk_dly[ch]);

        assign pre_act = ~pre_sync[ch];
        assign clr_act = ~clr_sync[ch];

        assign q_edge = edge_ok[ch]
                      ? ff_next(MODE_SEL, q_r[ch], dj_sync[ch], k_sync[ch])
                      : q_r[ch];

        assign q_next[ch] = pre_act ? 1'b1 :
                            clr_act ? 1'b0 :
                            q_edge;

        assign qb_next[ch] = (pre_act && clr_act) ? 1'b1 :
                             pre_act              ? 1'b0 :
                             clr_act              ? 1'b1 :
                             ~q_edge;
    end

    // Output registers; reset wins over every other condition.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_r  <= '0;
            qb_r <= '1;
        end else begin
            q_r  <= q_next;
            qb_r <= qb_next;
        end
    end

    assign Q  = q_r;
    assign QB = qb_r;

endmodule

// File: tb/tb_ic_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_ic_ff_bank
// Three banks share one system clock and reset: instance 0 is D mode with
// rising pin edges, instance 1 is JK mode with rising edges, instance 2 is
// T mode with falling edges. A reference model per instance is updated as
// stimulus is driven; the expected {Q,QB} is pushed onto a scoreboard with
// the cycle it must appear in and popped by a monitor on the falling CLK.
// ---------------------------------------------------------------------------
module tb_ic_ff_bank;

    logic CLK = 1'b0;
    logic RST_N;

    logic [1:0] pclk  [3];
    logic [1:0] pre_n [3];
    logic [1:0] clr_n [3];
    logic [1:0] dj    [3];
    logic [1:0] kk    [3];

    logic [1:0] q_d, qb_d, q_jk, qb_jk, q_t, qb_t;

    logic [1:0] m_q  [3];
    logic [1:0] m_qb [3];

    typedef struct {
        string      tag;
        int         due;
        int         inst;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    ic_ff_bank #(.CHANNELS(2), .MODE(0), .EDGE(1), .SYNC_STAGES(2)) dut_d (
        .CLK(CLK), .RST_N(RST_N), .PIN_CLK(pclk[0]), .PRE_N(pre_n[0]),
        .CLR_N(clr_n[0]), .DJ(dj[0]), .K(kk[0]), .Q(q_d), .QB(qb_d)
    );

    ic_ff_bank #(.CHANNELS(2), .MODE(1), .EDGE(1), .SYNC_STAGES(2)) dut_jk (
        .CLK(CLK), .RST_N(RST_N), .PIN_CLK(pclk[1]), .PRE_N(pre_n[1]),
        .CLR_N(clr_n[1]), .DJ(dj[1]), .K(kk[1]), .Q(q_jk), .QB(qb_jk)
    );

    ic_ff_bank #(.CHANNELS(2), .MODE(2), .EDGE(0), .SYNC_STAGES(2)) dut_t (
        .CLK(CLK), .RST_N(RST_N), .PIN_CLK(pclk[2]), .PRE_N(pre_n[2]),
        .CLR_N(clr_n[2]), .DJ(dj[2]), .K(kk[2]), .Q(q_t), .QB(qb_t)
    );

    // Active pin-clock level of each instance.
    function automatic logic edgeOf(int inst);
        return (inst == 2) ? 1'b0 : 1'b1;
    endfunction

    // Reference flip-flop behaviour; the instance index doubles as its mode.
    function automatic logic modelNext(int inst, logic q, logic d, logic k);
        logic r;
        r = q;
        if (inst == 0) begin
            r = d;
        end else if (inst == 1) begin
            if (d && k)       r = ~q;
            else if (d)       r = 1'b1;
            else if (k)       r = 1'b0;
        end else begin
            r = q ^ d;
        end
        return r;
    endfunction

    function automatic logic [3:0] observe(int inst);
        case (inst)
            0:       return {q_d, qb_d};
            1:       return {q_jk, qb_jk};
            default: return {q_t, qb_t};
        endcase
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic pushExpect(string tag, int inst, int lat);
        exp_t e;
        e.tag  = tag;
        e.due  = cyc + lat;
        e.inst = inst;
        e.val  = {m_q[inst], m_qb[inst]};
        sb.push_back(e);
    endtask

    // Scoreboard monitor: compares every entry that falls due this cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                checkOutput({e.tag, "_late"}, 32'(e.due), 32'(cyc));
            end else begin
                checkOutput(e.tag, 32'(observe(e.inst)), 32'(e.val));
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic setData(int inst, int ch, logic d, logic k);
        dj[inst][ch] = d;
        kk[inst][ch] = k;
    endtask

    // Drive pin clocks of the channels in mask to level; the value before
    // the event must still be visible one cycle before the update lands.
    task automatic applyStimulus(int inst, logic [1:0] mask, logic level, string tag);
        pushExpect({tag, "_pre"}, inst, 2);
        for (int ch = 0; ch < 2; ch++) begin
            if (mask[ch]) begin
                if (pclk[inst][ch] != level && level == edgeOf(inst) &&
                    pre_n[inst][ch] && clr_n[inst][ch]) begin
                    m_q[inst][ch]  = modelNext(inst, m_q[inst][ch], dj[inst][ch], kk[inst][ch]);
                    m_qb[inst][ch] = ~m_q[inst][ch];
                end
                pclk[inst][ch] = level;
            end
        end
        pushExpect(tag, inst, 3);
    endtask

    task automatic pclkPulse(int inst, logic [1:0] mask, string tag);
        applyStimulus(inst, mask, 1'b1, {tag, "_hi"});
        step(3);
        applyStimulus(inst, mask, 1'b0, {tag, "_lo"});
        step(3);
    endtask

    task automatic setOverride(int inst, int ch, logic pre, logic clr, string tag);
        pushExpect({tag, "_pre"}, inst, 2);
        pre_n[inst][ch] = pre;
        clr_n[inst][ch] = clr;
        if (!pre && !clr) begin
            m_q[inst][ch] = 1'b1; m_qb[inst][ch] = 1'b1;
        end else if (!pre) begin
            m_q[inst][ch] = 1'b1; m_qb[inst][ch] = 1'b0;
        end else if (!clr) begin
            m_q[inst][ch] = 1'b0; m_qb[inst][ch] = 1'b1;
        end else begin
            m_qb[inst][ch] = ~m_q[inst][ch];
        end
        pushExpect(tag, inst, 3);
    endtask

    task automatic doReset(int n, string tag);
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_q[i]  = 2'b00;
            m_qb[i] = 2'b11;
            pushExpect(tag, i, 2);
        end
        step(n);
        RST_N = 1'b1;
    endtask

    initial begin
        int guard;
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pclk[i]  = 2'b00;
            pre_n[i] = 2'b11;
            clr_n[i] = 2'b11;
            dj[i]    = 2'b00;
            kk[i]    = 2'b00;
            m_q[i]   = 2'b00;
            m_qb[i]  = 2'b11;
        end
        step(1);
        doReset(4, "reset");
        step(8);

        // D load with exact latency; channel 1 untouched.
        setData(0, 0, 1'b1, 1'b0);
        step(2);
        pclkPulse(0, 2'b01, "d_load1");

        // Preset and clear together, then released in the same cycle.
        setOverride(0, 1, 1'b0, 1'b0, "both_low");
        step(5);
        pushExpect("both_hold", 0, 1);
        setOverride(0, 1, 1'b1, 1'b1, "both_release");
        step(4);

        // An edge during clear is discarded and not replayed on release.
        setOverride(0, 1, 1'b1, 1'b0, "clr_only");
        step(3);
        setData(0, 1, 1'b1, 1'b0);
        step(2);
        pclkPulse(0, 2'b10, "edge_in_clr");
        setOverride(0, 1, 1'b1, 1'b1, "clr_release");
        step(4);

        // JK: toggle x4, reset, set, hold.
        setData(1, 0, 1'b1, 1'b1);
        step(2);
        repeat (4) pclkPulse(1, 2'b01, "jk_toggle");
        setData(1, 0, 1'b0, 1'b1);
        step(2);
        pclkPulse(1, 2'b01, "jk_reset");
        setData(1, 0, 1'b1, 1'b0);
        step(2);
        pclkPulse(1, 2'b01, "jk_set");
        setData(1, 0, 1'b0, 1'b0);
        step(2);
        pclkPulse(1, 2'b01, "jk_hold");
        setOverride(1, 1, 1'b0, 1'b1, "jk_preset");
        step(3);
        setOverride(1, 1, 1'b1, 1'b1, "jk_pre_rel");
        step(3);
        setOverride(1, 1, 1'b1, 1'b0, "jk_clear");
        step(3);
        setOverride(1, 1, 1'b1, 1'b1, "jk_clr_rel");
        step(4);

        // T on falling edges: rises do nothing, falls toggle.
        setData(2, 0, 1'b1, 1'b0);
        step(2);
        repeat (3) pclkPulse(2, 2'b01, "t_fall");
        setData(2, 1, 1'b1, 1'b0);
        step(2);
        pclkPulse(2, 2'b11, "t_both");
        setData(2, 1, 1'b0, 1'b0);
        step(2);
        pclkPulse(2, 2'b11, "t_ch1_zero");

        // Pin clock held high across reset release: no phantom load.
        setData(0, 0, 1'b1, 1'b0);
        step(2);
        applyStimulus(0, 2'b01, 1'b1, "d_rise_pre_reset");
        step(4);
        doReset(3, "reset2");
        for (int l = 1; l <= 6; l++) pushExpect("no_phantom", 0, l);
        step(7);
        applyStimulus(0, 2'b01, 1'b0, "d_low_after_reset");
        step(3);
        applyStimulus(0, 2'b01, 1'b1, "d_load_after_reset");
        step(3);
        setData(0, 0, 1'b0, 1'b0);
        step(2);
        applyStimulus(0, 2'b01, 1'b0, "d_low2");
        step(3);
        applyStimulus(0, 2'b01, 1'b1, "d_load0");
        step(4);

        // Reset one cycle after a pin edge is sampled flushes it.
        setData(0, 1, 1'b1, 1'b0);
        step(2);
        pclk[0][1] = 1'b1;
        step(1);
        doReset(2, "reset_flush");
        for (int l = 1; l <= 6; l++) pushExpect("no_late_update", 0, l);
        step(7);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            step(1);
            guard++;
        end
        if (sb.size() != 0) begin
            checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
